// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  idex_mem_read;
   logic [REG_ADDR_W-1:0] idex_rd;
   logic [REG_ADDR_W-1:0] ifid_rs1;
   logic [REG_ADDR_W-1:0] ifid_rs2;
   logic                  ifid_rs1_used;
   logic                  ifid_rs2_used;
   logic                  exmem_branch_taken;
   logic                  exmem_halt;
   logic                  dmem_busy;
   logic                  resume;
   logic                  pc_load;
   logic                  ifid_load;
   logic                  idex_load;
   logic                  exmem_load;
   logic                  memwb_load;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  exmem_flush;
   logic                  halted;
   logic                  mem_timeout;

   modport master (
      output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
             exmem_branch_taken, exmem_halt, dmem_busy, resume,
      input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
             ifid_flush, idex_flush, exmem_flush, halted, mem_timeout
   );

   modport slave (
      input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
             exmem_branch_taken, exmem_halt, dmem_busy, resume,
      output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
             ifid_flush, idex_flush, exmem_flush, halted, mem_timeout
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/halt sequencer with a data-memory wait watchdog.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 64
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        flush_events
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             timeout_reg, timeout_next;
   logic             load_use;

   assign load_use = hz.idex_mem_read && (hz.idex_rd != REG_ADDR_W'(0)) &&
                     ((hz.ifid_rs1_used && (hz.idex_rd == hz.ifid_rs1)) ||
                      (hz.ifid_rs2_used && (hz.idex_rd == hz.ifid_rs2)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= RUN;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      timeout_next = timeout_reg;
      case (state_reg)
         RUN: begin
            if (hz.dmem_busy) begin
               state_next = MEM_WAIT;
               cnt_next   = CNT_W'(1);
            end else if (hz.exmem_halt) begin
               state_next = HALT;
            end
         end
         MEM_WAIT: begin
            if (!hz.dmem_busy) begin
               state_next = RUN;
               cnt_next   = '0;
            end else if (cnt_reg == TIMEOUT_CNT) begin
               timeout_next = 1'b1;
               state_next   = HALT;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         HALT: begin
            cnt_next = '0;
            // A watchdog fault is only cleared by reset.
            if (hz.resume && !timeout_reg) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      hz.pc_load     = 1'b0;
      hz.ifid_load   = 1'b0;
      hz.idex_load   = 1'b0;
      hz.exmem_load  = 1'b0;
      hz.memwb_load  = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.halted      = (state_reg == HALT);
      hz.mem_timeout = timeout_reg;
      if (!rst && state_reg == RUN && !hz.dmem_busy) begin
         if (hz.exmem_halt) begin
            // Retire the halting instruction, squash everything younger.
            hz.memwb_load  = 1'b1;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
         end else if (hz.exmem_branch_taken) begin
            hz.pc_load     = 1'b1;
            hz.ifid_load   = 1'b1;
            hz.idex_load   = 1'b1;
            hz.exmem_load  = 1'b1;
            hz.memwb_load  = 1'b1;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
         end else if (load_use) begin
            hz.idex_load   = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_load  = 1'b1;
            hz.memwb_load  = 1'b1;
         end else begin
            hz.pc_load     = 1'b1;
            hz.ifid_load   = 1'b1;
            hz.idex_load   = 1'b1;
            hz.exmem_load  = 1'b1;
            hz.memwb_load  = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (state_reg != HALT && !hz.pc_load) stall_cycles <= stall_cycles + 32'd1;
         if (hz.exmem_flush)                    flush_events <= flush_events + 32'd1;
      end
   end
`endif

endmodule
